// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron configuration path: FSM states,
// default sizing constants and the per-neuron parameter record.
package lif_pkg;

  localparam int LIF_PARAM_W = 8;
  localparam int LIF_DEF_GAP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } lif_state_t;

  typedef struct packed {
    logic [LIF_PARAM_W-1:0] tau;
    logic [LIF_PARAM_W-1:0] weight;
    logic [LIF_PARAM_W-1:0] thresh;
  } lif_params_t;

endpackage

// File: rtl/lif_param_shadow.sv
// Register file mirroring the last parameters programmed into each neuron.
// Masked write port (one or all entries per write), combinational read port.
module lif_param_shadow
  import lif_pkg::*;
#(
  parameter int  N_NEURONS = 4,
  parameter int  IDX_W     = 2,
  parameter type entry_t   = lif_params_t
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [N_NEURONS-1:0] wr_mask,
  input  entry_t               wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output entry_t               rd_data
);

  entry_t regs [N_NEURONS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (wr_mask[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Out-of-range read indices return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = regs[i];
      end
    end
  end

endmodule

// File: rtl/lif_cfg_sequencer.sv
// Host-side sequencer that serialises tau/weight/threshold words LSB-first
// into the LIF neuron parameter loaders, framed by per-neuron set_vars.
module lif_cfg_sequencer
  import lif_pkg::*;
#(
  parameter int  N_NEURONS  = 4,
  parameter int  WIDTH      = LIF_PARAM_W,
  parameter int  GAP_CYCLES = LIF_DEF_GAP,
  localparam int IDX_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_idx,
  input  logic                 req_bcast,
  input  logic [WIDTH-1:0]     req_tau,
  input  logic [WIDTH-1:0]     req_weight,
  input  logic [WIDTH-1:0]     req_thresh,
  output logic [N_NEURONS-1:0] set_vars,
  output logic                 expd,
  output logic                 w,
  output logic                 t,
  output logic                 busy,
  output logic                 done,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WIDTH-1:0]     rd_tau,
  output logic [WIDTH-1:0]     rd_weight,
  output logic [WIDTH-1:0]     rd_thresh
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] tau;
    logic [WIDTH-1:0] weight;
    logic [WIDTH-1:0] thresh;
  } params_t;

  lif_state_t           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
  params_t              words, words_n;
  logic [N_NEURONS-1:0] mask, mask_n;
  logic [N_NEURONS-1:0] set_vars_n;
  logic                 expd_n, w_n, t_n, done_n;
  logic                 shadow_we;
  logic [N_NEURONS-1:0] onehot;
  logic                 idx_ok;
  params_t              rd_data;

  // An index past N_NEURONS decodes to an empty mask, so the request is
  // swallowed by the handshake without starting a frame.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      onehot[i] = (req_idx == IDX_W'(i));
    end
    idx_ok = req_bcast | (|onehot);
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gap_cnt  <= '0;
      words    <= '0;
      mask     <= '0;
      set_vars <= '0;
      expd     <= 1'b0;
      w        <= 1'b0;
      t        <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      gap_cnt  <= gap_cnt_n;
      words    <= words_n;
      mask     <= mask_n;
      set_vars <= set_vars_n;
      expd     <= expd_n;
      w        <= w_n;
      t        <= t_n;
      done     <= done_n;
    end
  end

  // The serial outputs are registered, so each branch computes the value the
  // lines carry during the cycle after the coming edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gap_cnt_n  = gap_cnt;
    words_n    = words;
    mask_n     = mask;
    set_vars_n = '0;
    expd_n     = 1'b0;
    w_n        = 1'b0;
    t_n        = 1'b0;
    done_n     = 1'b0;
    shadow_we  = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && idx_ok) begin
          words_n.tau    = req_tau;
          words_n.weight = req_weight;
          words_n.thresh = req_thresh;
          mask_n         = req_bcast ? {N_NEURONS{1'b1}} : onehot;
          cnt_n          = '0;
          state_n        = SHIFT;
          set_vars_n     = mask_n;
          expd_n         = req_tau[0];
          w_n            = req_weight[0];
          t_n            = req_thresh[0];
        end
      end

      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          done_n    = 1'b1;
          shadow_we = 1'b1;
          gap_cnt_n = '0;
          // The IDLE cycle before the next accept is itself a low cycle,
          // so GAP only needs to cover the remaining GAP_CYCLES-1.
          state_n   = (GAP_CYCLES > 1) ? GAP : IDLE;
        end else begin
          cnt_n      = cnt + 1'b1;
          set_vars_n = mask;
          expd_n     = words.tau[cnt_n[SEL_W-1:0]];
          w_n        = words.weight[cnt_n[SEL_W-1:0]];
          t_n        = words.thresh[cnt_n[SEL_W-1:0]];
        end
      end

      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 2)) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  lif_param_shadow #(
    .N_NEURONS (N_NEURONS),
    .IDX_W     (IDX_W),
    .entry_t   (params_t)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shadow_we),
    .wr_mask (mask),
    .wr_data (words),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign rd_tau    = rd_data.tau;
  assign rd_weight = rd_data.weight;
  assign rd_thresh = rd_data.thresh;

endmodule

// File: tb/tb_lif_cfg_sequencer.sv
// Directed bench for lif_cfg_sequencer: a 4-neuron instance for the main
// traffic and a 3-neuron instance for the unreachable-index case.
module tb_lif_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst;

  logic       req_valid, req_ready, req_bcast;
  logic [1:0] req_idx, rd_idx;
  logic [7:0] req_tau, req_weight, req_thresh;
  logic [3:0] set_vars;
  logic       expd, w, t, busy, done;
  logic [7:0] rd_tau, rd_weight, rd_thresh;

  logic       req_valid3, req_ready3, req_bcast3;
  logic [1:0] req_idx3, rd_idx3;
  logic [7:0] req_tau3, req_weight3, req_thresh3;
  logic [2:0] set_vars3;
  logic       expd3, w3, t3, busy3, done3;
  logic [7:0] rd_tau3, rd_weight3, rd_thresh3;

  int checks = 0;
  int errors = 0;

  logic [7:0] ld_tau [4];
  logic [7:0] ld_w   [4];
  logic [7:0] ld_t   [4];

  always #5 clk = ~clk;

  lif_cfg_sequencer #(.N_NEURONS(4), .WIDTH(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_bcast(req_bcast), .req_tau(req_tau), .req_weight(req_weight),
    .req_thresh(req_thresh), .set_vars(set_vars), .expd(expd), .w(w), .t(t),
    .busy(busy), .done(done), .rd_idx(rd_idx),
    .rd_tau(rd_tau), .rd_weight(rd_weight), .rd_thresh(rd_thresh)
  );

  lif_cfg_sequencer #(.N_NEURONS(3), .WIDTH(8), .GAP_CYCLES(2)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_idx(req_idx3),
    .req_bcast(req_bcast3), .req_tau(req_tau3), .req_weight(req_weight3),
    .req_thresh(req_thresh3), .set_vars(set_vars3), .expd(expd3), .w(w3), .t(t3),
    .busy(busy3), .done(done3), .rd_idx(rd_idx3),
    .rd_tau(rd_tau3), .rd_weight(rd_weight3), .rd_thresh(rd_thresh3)
  );

  // Behavioural neuron loader: shifts LSB-first while its set_vars is high.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (set_vars[i]) begin
        ld_tau[i] <= {expd, ld_tau[i][7:1]};
        ld_w[i]   <= {w,    ld_w[i][7:1]};
        ld_t[i]   <= {t,    ld_t[i][7:1]};
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkShadow(input string tag, input logic [1:0] idx,
                             input logic [7:0] e_tau, input logic [7:0] e_w, input logic [7:0] e_t);
    rd_idx = idx;
    #1;
    checkOutput({tag, "_tau"}, rd_tau, e_tau);
    checkOutput({tag, "_w"}, rd_weight, e_w);
    checkOutput({tag, "_t"}, rd_thresh, e_t);
  endtask

  // Presents a request at a negedge and returns just after the accepting edge.
  task automatic applyStimulus(input logic [1:0] idx, input logic bcast,
                               input logic [7:0] tau, input logic [7:0] wt, input logic [7:0] th);
    int k;
    @(negedge clk);
    req_idx    = idx;
    req_bcast  = bcast;
    req_tau    = tau;
    req_weight = wt;
    req_thresh = th;
    req_valid  = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] a_tau, a_w, a_t, b_tau, b_w, b_t;
    int acc [2];
    int n, low_run, min_gap;
    logic seen, switched;

    rst = 1'b1;
    req_valid = 0; req_idx = 0; req_bcast = 0; req_tau = 0; req_weight = 0; req_thresh = 0; rd_idx = 0;
    req_valid3 = 0; req_idx3 = 0; req_bcast3 = 0; req_tau3 = 0; req_weight3 = 0; req_thresh3 = 0; rd_idx3 = 0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_sv", set_vars, 0);
    checkOutput("rst_lines", {expd, w, t}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) checkShadow($sformatf("rst_sh%0d", i), 2'(i), 8'h00, 8'h00, 8'h00);

    $display("[TB] single write to neuron 1");
    a_tau = 8'hA5; a_w = 8'h3C; a_t = 8'h81;
    applyStimulus(2'd1, 1'b0, a_tau, a_w, a_t);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("single_sv%0d", k), set_vars, 4'b0010);
      checkOutput($sformatf("single_expd%0d", k), expd, a_tau[k]);
      checkOutput($sformatf("single_w%0d", k), w, a_w[k]);
      checkOutput($sformatf("single_t%0d", k), t, a_t[k]);
      checkOutput($sformatf("single_done%0d", k), done, 0);
      checkOutput($sformatf("single_busy%0d", k), busy, 1);
      if (k == 7) checkShadow("single_old", 2'd1, 8'h00, 8'h00, 8'h00);
    end
    @(negedge clk);
    checkOutput("single_sv_fall", set_vars, 0);
    checkOutput("single_done_hi", done, 1);
    checkOutput("single_lines_gap", {expd, w, t}, 0);
    checkOutput("single_ready_gap", req_ready, 0);
    checkOutput("single_ld_tau", ld_tau[1], a_tau);
    checkOutput("single_ld_w", ld_w[1], a_w);
    checkOutput("single_ld_t", ld_t[1], a_t);
    checkShadow("single_new", 2'd1, a_tau, a_w, a_t);
    checkShadow("single_other", 2'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("single_done_lo", done, 0);
    checkOutput("single_ready_back", req_ready, 1);
    checkOutput("single_busy_lo", busy, 0);

    $display("[TB] broadcast write");
    applyStimulus(2'd2, 1'b1, 8'hFF, 8'h00, 8'h55);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bcast_sv%0d", k), set_vars, 4'b1111);
    end
    @(negedge clk);
    checkOutput("bcast_done", done, 1);
    checkOutput("bcast_sv_fall", set_vars, 0);
    for (int i = 0; i < 4; i++) begin
      checkShadow($sformatf("bcast_sh%0d", i), 2'(i), 8'hFF, 8'h00, 8'h55);
      checkOutput($sformatf("bcast_ld_tau%0d", i), ld_tau[i], 8'hFF);
      checkOutput($sformatf("bcast_ld_t%0d", i), ld_t[i], 8'h55);
    end
    repeat (2) @(negedge clk);

    $display("[TB] back-to-back requests");
    a_tau = 8'h11; a_w = 8'h22; a_t = 8'h33;
    b_tau = 8'h44; b_w = 8'h5A; b_t = 8'h66;
    req_idx = 2'd2; req_bcast = 0; req_tau = a_tau; req_weight = a_w; req_thresh = a_t;
    req_valid = 1'b1;
    n = 0; low_run = 0; min_gap = 99; seen = 0; switched = 0;
    acc[0] = -1; acc[1] = -1;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (n == 1 && !switched) begin
        req_idx = 2'd3; req_tau = b_tau; req_weight = b_w; req_thresh = b_t;
        switched = 1;
      end
      if (n == 2 && req_valid) req_valid = 1'b0;
      if (set_vars == 4'b0000) begin
        low_run++;
      end else begin
        if (seen && low_run > 0 && low_run < min_gap) min_gap = low_run;
        seen = 1;
        low_run = 0;
      end
      if (req_valid && req_ready && n < 2) begin
        acc[n] = c;
        n++;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b_accepts", n, 2);
    checkOutput("b2b_spacing", acc[1] - acc[0], 10);
    checkOutput("b2b_min_gap", min_gap, 2);
    checkShadow("b2b_first", 2'd2, a_tau, a_w, a_t);
    checkShadow("b2b_second", 2'd3, b_tau, b_w, b_t);
    checkOutput("b2b_ld3_w", ld_w[3], b_w);

    $display("[TB] unreachable index on 3-neuron instance");
    @(negedge clk);
    req_idx3 = 2'd3; req_bcast3 = 0; req_tau3 = 8'hEE; req_weight3 = 8'hDD; req_thresh3 = 8'hCC;
    req_valid3 = 1'b1;
    checkOutput("ill_ready_pre", req_ready3, 1);
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ill_sv%0d", k), set_vars3, 0);
      checkOutput($sformatf("ill_done%0d", k), done3, 0);
      checkOutput($sformatf("ill_ready%0d", k), req_ready3, 1);
      checkOutput($sformatf("ill_busy%0d", k), busy3, 0);
    end
    for (int i = 0; i < 3; i++) begin
      rd_idx3 = 2'(i);
      #1;
      checkOutput($sformatf("ill_sh%0d", i), {rd_tau3, rd_weight3, rd_thresh3}, 0);
    end
    @(negedge clk);
    req_idx3 = 2'd2; req_tau3 = 8'h96; req_weight3 = 8'h69; req_thresh3 = 8'hF0;
    req_valid3 = 1'b1;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    @(negedge clk);
    checkOutput("n3_sv", set_vars3, 3'b100);
    repeat (8) @(negedge clk);
    checkOutput("n3_done", done3, 1);
    rd_idx3 = 2'd2;
    #1;
    checkOutput("n3_sh2", {rd_tau3, rd_weight3, rd_thresh3}, 24'h9669F0);

    $display("[TB] reset during shift");
    repeat (2) @(negedge clk);
    applyStimulus(2'd2, 1'b0, 8'hC7, 8'h18, 8'h2B);
    for (int k = 0; k < 5; k++) @(negedge clk);
    checkOutput("rmid_sv_pre", set_vars, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rmid_sv", set_vars, 0);
    checkOutput("rmid_lines", {expd, w, t}, 0);
    checkOutput("rmid_ready", req_ready, 1);
    checkOutput("rmid_busy", busy, 0);
    checkOutput("rmid_done", done, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) checkShadow($sformatf("rmid_sh%0d", i), 2'(i), 8'h00, 8'h00, 8'h00);

    $display("[TB] write after reset, shadow timing on neuron 0");
    a_tau = 8'h5A; a_w = 8'hC3; a_t = 8'h7E;
    applyStimulus(2'd0, 1'b0, a_tau, a_w, a_t);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_sv%0d", k), set_vars, 4'b0001);
      checkOutput($sformatf("post_expd%0d", k), expd, a_tau[k]);
    end
    checkShadow("post_old", 2'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("post_done", done, 1);
    checkShadow("post_new", 2'd0, a_tau, a_w, a_t);
    checkOutput("post_ld_tau", ld_tau[0], a_tau);
    checkOutput("post_ld_w", ld_w[0], a_w);
    @(negedge clk);
    checkOutput("post_done_lo", done, 0);
    checkOutput("post_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
